// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: request and result handshakes between the EXE stage and the multiply issue controller.
interface mul_issue_ctrl_if #(parameter int TAG_W = 5);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_src1;
    logic [31:0]      req_src2;
    logic [TAG_W-1:0] req_tag;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    modport master (
        output req_valid, req_op, req_src1, req_src2, req_tag, res_ready,
        input  req_ready, res_valid, res_data, res_tag
    );
    modport slave (
        input  req_valid, req_op, req_src1, req_src2, req_tag, res_ready,
        output req_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues MUL.W/MULH.W/MULH.WU to the two-stage multiplier and queues results (2 deep).
// Define MUL_ISSUE_PERF_EN to add the perf_issue_cnt / perf_stall_cnt counters.
module mul_issue_ctrl #(
    parameter int TAG_W   = 5,
    parameter int Q_DEPTH = 2
) (
    input  logic        mul_clk,
    input  logic        resetn,
    mul_issue_ctrl_if.slave bus,
    input  logic        flush,
    output logic        m_signed,
    output logic [31:0] m_x,
    output logic [31:0] m_y,
    output logic        m_reset,
    input  logic [63:0] m_result
`ifdef MUL_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    logic             inflightV;
    logic [1:0]       pendOp;
    logic [TAG_W-1:0] pendTag;
    logic [1:0]       count;
    logic [TAG_W+31:0] head, tail, landing;
    logic             issue, push, pop;
    logic [2:0]       occ;

    assign m_reset  = ~resetn;
    assign m_x      = resetn ? bus.req_src1 : '0;
    assign m_y      = resetn ? bus.req_src2 : '0;
    assign m_signed = resetn & (bus.req_op == 2'b01);

    // Occupancy the queue will see next cycle; an issue now needs one slot free then.
    assign pop           = bus.res_valid & bus.res_ready;
    assign occ           = {1'b0, count} + {2'b0, inflightV} - {2'b0, pop};
    assign bus.req_ready = resetn & ~flush & (occ <= 3'(Q_DEPTH - 1));
    assign issue         = bus.req_valid & bus.req_ready;
    assign push          = inflightV & ~flush;
    assign landing       = {pendTag, (pendOp[0] ^ pendOp[1]) ? m_result[63:32] : m_result[31:0]};
    assign bus.res_valid = count != 2'd0;
    assign {bus.res_tag, bus.res_data} = head;

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            inflightV <= 1'b0;
            pendOp    <= '0;
            pendTag   <= '0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            inflightV <= issue;
            if (issue) begin
                pendOp  <= bus.req_op;
                pendTag <= bus.req_tag;
            end
            count <= flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
            head  <= pop ? (count == 2'd2 ? tail : landing) : (count == 2'd0 ? landing : head);
            tail  <= (count == 2'd2 && !pop) ? tail : landing;
        end
    end

`ifdef MUL_ISSUE_PERF_EN
    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(issue);
            perf_stall_cnt <= perf_stall_cnt + 32'(bus.req_valid & ~bus.req_ready & ~flush);
        end
    end
`endif
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed vectors for mul_issue_ctrl against a behavioural two-stage multiplier.
module tb_mul_issue_ctrl;
    logic        mul_clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        m_signed;
    logic [31:0] m_x, m_y;
    logic        m_reset;
    logic [63:0] m_result;
`ifdef MUL_ISSUE_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif
    int vectors = 0;
    int miscompares = 0;
    int k;

    mul_issue_ctrl_if #(.TAG_W(5)) bus ();

    mul_issue_ctrl #(.TAG_W(5), .Q_DEPTH(2)) dut (
        .mul_clk  (mul_clk),
        .resetn   (resetn),
        .bus      (bus.slave),
        .flush    (flush),
        .m_signed (m_signed),
        .m_x      (m_x),
        .m_y      (m_y),
        .m_reset  (m_reset),
        .m_result (m_result)
`ifdef MUL_ISSUE_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 mul_clk = ~mul_clk;

    // Operands registered at the edge, product visible the following cycle.
    always @(posedge mul_clk or posedge m_reset)
        if (m_reset) m_result <= '0;
        else m_result <= m_signed ? $signed({{32{m_x[31]}}, m_x}) * $signed({{32{m_y[31]}}, m_y})
                                  : {32'b0, m_x} * {32'b0, m_y};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_tag   = tag;
    endtask

    task automatic single(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp);
        drive(1'b1, op, a, b, tag);
        #1;
        check({name, "_ready"}, bus.req_ready, 1);
        check({name, "_signed"}, m_signed, op == 2'b01);
        tick();
        bus.req_valid = 1'b0;
        check({name, "_lat1"}, bus.res_valid, 0);
        tick();
        check({name, "_valid"}, bus.res_valid, 1);
        check({name, "_data"}, bus.res_data, exp);
        check({name, "_tag"}, bus.res_tag, tag);
        tick();
        check({name, "_drained"}, bus.res_valid, 0);
    endtask

    initial begin
        resetn = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 2'b01, 32'h1234, 32'h5678, 5'd0);
        bus.res_ready = 1'b1;
        #12;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_m_reset", m_reset, 1);
        check("rst_m_x", m_x, 0);
        check("rst_m_signed", m_signed, 0);
        #5 resetn = 1'b1;
        tick();
        check("run_m_reset", m_reset, 0);

        single("mulw", 2'b00, 32'h7FFFFFFF, 32'h00000002, 5'd3, 32'hFFFFFFFE);
        single("mulhw_m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h00000000);
        single("mulhwu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFE);
        single("mulhw_min", 2'b01, 32'h80000000, 32'h80000000, 5'd9, 32'h40000000);
        single("op11", 2'b11, 32'h00010001, 32'h00010000, 5'd31, 32'h00010000);

        for (int c = 0; c < 6; c++) begin
            drive(c < 4, 2'b00, 32'(c + 1), 32'd3, 5'(c + 1));
            #1;
            if (c < 4) check("b2b_ready", bus.req_ready, 1);
            if (c >= 2) begin
                check("b2b_valid", bus.res_valid, 1);
                check("b2b_data", bus.res_data, 32'((c - 1) * 3));
                check("b2b_tag", bus.res_tag, 32'(c - 1));
            end
            tick();
        end
        bus.req_valid = 1'b0;
        check("b2b_drained", bus.res_valid, 0);

        bus.res_ready = 1'b0;
        k = 0;
        for (int p = 0; p < 6; p++) begin
            drive(1'b1, 2'b00, 32'(100 + k), 32'd1, 5'(k));
            #1;
            check("bp_ready", bus.req_ready, p < 2);
            if (p >= 2) check("bp_head", bus.res_data, 100);
            if (bus.req_ready) k++;
            tick();
        end
        bus.res_ready = 1'b1;
        for (int q = 0; q < 5; q++) begin
            drive(q < 2, 2'b00, 32'(100 + k), 32'd1, 5'(k));
            #1;
            if (q < 2) check("bp_resume_ready", bus.req_ready, 1);
            check("bp_drain_valid", bus.res_valid, q < 4);
            if (q < 4) check("bp_drain_data", bus.res_data, 32'(100 + q));
            if (bus.req_valid && bus.req_ready) k++;
            tick();
        end
        check("bp_accepted", 32'(k), 4);

        bus.res_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd200, 32'd1, 5'd10);
        #1 check("fl_a_ready", bus.req_ready, 1);
        tick();
        drive(1'b1, 2'b00, 32'd201, 32'd1, 5'd11);
        #1 check("fl_b_ready", bus.req_ready, 1);
        tick();
        bus.res_ready = 1'b1;
        drive(1'b1, 2'b00, 32'd202, 32'd1, 5'd12);
        flush = 1'b1;
        #1;
        check("fl_ready", bus.req_ready, 0);
        check("fl_head", bus.res_data, 200);
        tick();
        flush = 1'b0;
        check("fl_after_valid", bus.res_valid, 0);
        #1 check("fl_after_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check("fl_lat1", bus.res_valid, 0);
        tick();
        check("fl_c_valid", bus.res_valid, 1);
        check("fl_c_data", bus.res_data, 202);
        check("fl_c_tag", bus.res_tag, 12);
        tick();
        check("fl_only_one", bus.res_valid, 0);

        bus.res_ready = 1'b0;
        drive(1'b1, 2'b00, 32'd9, 32'd9, 5'd9);
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("pre_arst_valid", bus.res_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_res_valid", bus.res_valid, 0);
        check("arst_m_reset", m_reset, 1);
        check("arst_req_ready", bus.req_ready, 0);
        tick();
        #2 resetn = 1'b1;
        bus.res_ready = 1'b1;
        single("post_rst", 2'b00, 32'd5, 32'd7, 5'd4, 32'd35);
`ifdef MUL_ISSUE_PERF_EN
        check("perf_issue", perf_issue_cnt, 1);
        check("perf_stall", perf_stall_cnt, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
